// File: rtl/hicore_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hicore_lsu_ctrl
// Brief    : Load/store unit front end ahead of the DTCM controller. Takes a
//            single load/store request, screens it for alignment, issues a
//            word-aligned ICB command, formats the read response and returns
//            exactly one writeback record per request.
// Revision : 1.0 - initial release
// ============================================================================
module hicore_lsu_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // request from execute stage
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_req_load,
    input  logic [1:0]      lsu_req_size,
    input  logic            lsu_req_usign,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [4:0]      lsu_req_rd,
    // ICB command channel
    output logic            mem_icb_cmd_valid,
    input  logic            mem_icb_cmd_ready,
    output logic            mem_icb_cmd_read,
    output logic [AW-1:0]   mem_icb_cmd_addr,
    output logic [DW-1:0]   mem_icb_cmd_wdata,
    output logic [DW/8-1:0] mem_icb_cmd_wmask,
    // ICB response channel
    input  logic            mem_icb_rsp_valid,
    output logic            mem_icb_rsp_ready,
    input  logic            mem_icb_rsp_err,
    input  logic [DW-1:0]   mem_icb_rsp_rdata,
    // writeback record
    output logic            lsu_wb_valid,
    input  logic            lsu_wb_ready,
    output logic [DW-1:0]   lsu_wb_rdata,
    output logic [4:0]      lsu_wb_rd,
    output logic            lsu_wb_err,
    output logic            lsu_wb_misalign,
    output logic [AW-1:0]   lsu_wb_badaddr
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CMD  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_WB   = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    // request fields needed to format the response
    logic            r_load;
    logic [1:0]      r_size;
    logic            r_usign;
    logic [1:0]      r_lane_off;

    // registered ICB command
    logic            r_cmd_read;
    logic [AW-1:0]   r_cmd_addr;
    logic [DW-1:0]   r_cmd_wdata;
    logic [DW/8-1:0] r_cmd_wmask;

    // registered writeback record
    logic [DW-1:0]   r_wb_rdata;
    logic [4:0]      r_wb_rd;
    logic            r_wb_err;
    logic            r_wb_misalign;
    logic [AW-1:0]   r_wb_badaddr;

    logic            w_req_hs;
    logic            w_cmd_hs;
    logic            w_rsp_hs;
    logic            w_wb_hs;
    logic            w_misalign;
    logic [DW-1:0]   w_st_wdata;
    logic [DW/8-1:0] w_st_wmask;
    logic [DW-1:0]   w_lane;
    logic [DW-1:0]   w_ld_data;

    assign lsu_req_ready     = (r_state == c_S_IDLE);
    assign mem_icb_cmd_valid = (r_state == c_S_CMD);
    assign mem_icb_rsp_ready = (r_state == c_S_WAIT);
    assign lsu_wb_valid      = (r_state == c_S_WB);

    assign w_req_hs = lsu_req_valid     & lsu_req_ready;
    assign w_cmd_hs = mem_icb_cmd_valid & mem_icb_cmd_ready;
    assign w_rsp_hs = mem_icb_rsp_valid & mem_icb_rsp_ready;
    assign w_wb_hs  = lsu_wb_valid      & lsu_wb_ready;

    assign mem_icb_cmd_read  = r_cmd_read;
    assign mem_icb_cmd_addr  = r_cmd_addr;
    assign mem_icb_cmd_wdata = r_cmd_wdata;
    assign mem_icb_cmd_wmask = r_cmd_wmask;

    assign lsu_wb_rdata    = r_wb_rdata;
    assign lsu_wb_rd       = r_wb_rd;
    assign lsu_wb_err      = r_wb_err;
    assign lsu_wb_misalign = r_wb_misalign;
    assign lsu_wb_badaddr  = r_wb_badaddr;

    // Alignment screen and store lane formatting from the live request
    always_comb begin
        w_misalign = 1'b0;
        w_st_wdata = lsu_req_wdata;
        w_st_wmask = 4'b1111;
        case (lsu_req_size)
            c_SZ_BYTE: begin
                w_st_wdata = {4{lsu_req_wdata[7:0]}};
                w_st_wmask = 4'b0001 << lsu_req_addr[1:0];
            end
            c_SZ_HALF: begin
                w_misalign = lsu_req_addr[0];
                w_st_wdata = {2{lsu_req_wdata[15:0]}};
                w_st_wmask = 4'b0011 << {lsu_req_addr[1], 1'b0};
            end
            c_SZ_WORD: begin
                w_misalign = (lsu_req_addr[1:0] != 2'b00);
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    // Load response: shift the addressed lane down, then sign/zero extend
    always_comb begin
        w_lane    = mem_icb_rsp_rdata >> {r_lane_off, 3'b000};
        w_ld_data = mem_icb_rsp_rdata;
        case (r_size)
            c_SZ_BYTE: w_ld_data = {{(DW-8){w_lane[7] & ~r_usign}}, w_lane[7:0]};
            c_SZ_HALF: w_ld_data = {{(DW-16){w_lane[15] & ~r_usign}}, w_lane[15:0]};
            default:   w_ld_data = mem_icb_rsp_rdata;
        endcase
    end

    // Next-state decode; a new request is only taken from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_req_hs) w_state_nxt = w_misalign ? c_S_WB : c_S_CMD;
            c_S_CMD:  if (w_cmd_hs) w_state_nxt = c_S_WAIT;
            c_S_WAIT: if (w_rsp_hs) w_state_nxt = c_S_WB;
            c_S_WB:   if (w_wb_hs)  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Capture request, build command, and assemble the writeback record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load        <= 1'b0;
            r_size        <= 2'b00;
            r_usign       <= 1'b0;
            r_lane_off    <= 2'b00;
            r_cmd_read    <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_wdata   <= '0;
            r_cmd_wmask   <= '0;
            r_wb_rdata    <= '0;
            r_wb_rd       <= 5'd0;
            r_wb_err      <= 1'b0;
            r_wb_misalign <= 1'b0;
            r_wb_badaddr  <= '0;
        end else begin
            if (w_req_hs) begin
                r_load        <= lsu_req_load;
                r_size        <= lsu_req_size;
                r_usign       <= lsu_req_usign;
                r_lane_off    <= lsu_req_addr[1:0];
                r_wb_rd       <= lsu_req_load ? lsu_req_rd : 5'd0;
                r_wb_badaddr  <= lsu_req_addr;
                r_wb_rdata    <= '0;
                r_wb_err      <= 1'b0;
                r_wb_misalign <= w_misalign;
                // A misaligned request never reaches the bus, so the command
                // registers keep their previous contents.
                if (!w_misalign) begin
                    r_cmd_read  <= lsu_req_load;
                    r_cmd_addr  <= {lsu_req_addr[AW-1:2], 2'b00};
                    r_cmd_wdata <= lsu_req_load ? '0 : w_st_wdata;
                    r_cmd_wmask <= lsu_req_load ? 4'b1111 : w_st_wmask;
                end
            end
            if (w_rsp_hs) begin
                r_wb_err   <= mem_icb_rsp_err;
                r_wb_rdata <= (r_load && !mem_icb_rsp_err) ? w_ld_data : '0;
            end
        end
    end

endmodule
`default_nettype wire
